// File: rtl/mat_row_bank.sv
// Multi-bank complex-matrix row store with two 1-cycle read ports, one write port and a bank copy engine.
// Optional write-first forwarding of same-cycle writes to reads: define MAT_ROW_BANK_BYPASS_EN.
module mat_row_bank #(
    parameter int SIZE      = 4,
    parameter int WIDTH     = 64,
    parameter int NUM_BANKS = 4,
    localparam int AW       = $clog2(SIZE),
    localparam int BW       = $clog2(NUM_BANKS),
    localparam int EW       = 2 * WIDTH,
    localparam int ROW_W    = SIZE * EW
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             a_rd_valid_i,
    input  logic [BW-1:0]    a_rd_bank_i,
    input  logic [AW-1:0]    a_rd_addr_i,
    input  logic             a_rd_col_i,
    output logic [ROW_W-1:0] a_rd_row_o,
    output logic [AW-1:0]    a_rd_addr_o,
    output logic             a_rd_rvalid_o,
    input  logic             b_rd_valid_i,
    input  logic [BW-1:0]    b_rd_bank_i,
    input  logic [AW-1:0]    b_rd_addr_i,
    input  logic             b_rd_col_i,
    output logic [ROW_W-1:0] b_rd_row_o,
    output logic [AW-1:0]    b_rd_addr_o,
    output logic             b_rd_rvalid_o,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [BW-1:0]    wr_bank_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [ROW_W-1:0] wr_row_i,
    input  logic             copy_valid_i,
    input  logic [BW-1:0]    copy_src_i,
    input  logic [BW-1:0]    copy_dst_i,
    input  logic             copy_transpose_i,
    output logic             copy_done_o,
    output logic             copy_err_o,
    output logic             busy_o
);

    typedef logic [ROW_W-1:0] mat_t [SIZE];
    typedef mat_t bank_arr_t [NUM_BANKS];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COPY,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    src_q, src_d;
    logic [BW-1:0]    dst_q, dst_d;
    logic             tr_q, tr_d;
    logic             err_q, err_d;
    bank_arr_t        mem_q, mem_d;
    bank_arr_t        rd_view;
    logic [ROW_W-1:0] a_row_q, a_row_d;
    logic [AW-1:0]    a_addr_q, a_addr_d;
    logic             a_rvalid_q, a_rvalid_d;
    logic [ROW_W-1:0] b_row_q, b_row_d;
    logic [AW-1:0]    b_addr_q, b_addr_d;
    logic             b_rvalid_q, b_rvalid_d;

    function automatic logic bank_ok(input logic [BW-1:0] bank);
        return int'(bank) < NUM_BANKS;
    endfunction

    // Gathers element c of every row, packed in row order as a row.
    function automatic logic [ROW_W-1:0] column_of(input mat_t m, input logic [AW-1:0] c);
        logic [ROW_W-1:0] g;
        g = '0;
        for (int r = 0; r < SIZE; r++) begin
            g[r*EW +: EW] = m[r][int'(c)*EW +: EW];
        end
        return g;
    endfunction

    function automatic logic [ROW_W-1:0] read_view(input bank_arr_t v, input logic [BW-1:0] bank,
                                                   input logic [AW-1:0] addr, input logic col);
        if (!bank_ok(bank)) begin
            return '0;
        end
        if (col) begin
            return column_of(v[bank], addr);
        end
        return v[bank][addr];
    endfunction

    assign busy_o      = (state_q != ST_IDLE);
    assign wr_ready_o  = (state_q == ST_IDLE);
    assign copy_done_o = (state_q == ST_DONE);
    assign copy_err_o  = err_q;

    assign a_rd_row_o    = a_row_q;
    assign a_rd_addr_o   = a_addr_q;
    assign a_rd_rvalid_o = a_rvalid_q;
    assign b_rd_row_o    = b_row_q;
    assign b_rd_addr_o   = b_addr_q;
    assign b_rd_rvalid_o = b_rvalid_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        tr_d    = tr_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (copy_valid_i) begin
                    if (copy_src_i != copy_dst_i && bank_ok(copy_src_i) && bank_ok(copy_dst_i)) begin
                        src_d   = copy_src_i;
                        dst_d   = copy_dst_i;
                        tr_d    = copy_transpose_i;
                        cnt_d   = '0;
                        state_d = ST_COPY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_COPY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(SIZE - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The copy engine and the external port never write together: the port is only ready while idle.
    always_comb begin
        mem_d = mem_q;
        if (state_q == ST_COPY) begin
            mem_d[dst_q][cnt_q] = tr_q ? column_of(mem_q[src_q], cnt_q) : mem_q[src_q][cnt_q];
        end else if (wr_valid_i && wr_ready_o && bank_ok(wr_bank_i)) begin
            mem_d[wr_bank_i][wr_addr_i] = wr_row_i;
        end
    end

`ifdef MAT_ROW_BANK_BYPASS_EN
    assign rd_view = mem_d;
`else
    assign rd_view = mem_q;
`endif

    always_comb begin
        a_row_d    = a_row_q;
        a_addr_d   = a_addr_q;
        a_rvalid_d = a_rd_valid_i;
        b_row_d    = b_row_q;
        b_addr_d   = b_addr_q;
        b_rvalid_d = b_rd_valid_i;
        if (a_rd_valid_i) begin
            a_row_d  = read_view(rd_view, a_rd_bank_i, a_rd_addr_i, a_rd_col_i);
            a_addr_d = a_rd_addr_i;
        end
        if (b_rd_valid_i) begin
            b_row_d  = read_view(rd_view, b_rd_bank_i, b_rd_addr_i, b_rd_col_i);
            b_addr_d = b_rd_addr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            tr_q       <= 1'b0;
            err_q      <= 1'b0;
            mem_q      <= '{default: '0};
            a_row_q    <= '0;
            a_addr_q   <= '0;
            a_rvalid_q <= 1'b0;
            b_row_q    <= '0;
            b_addr_q   <= '0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            tr_q       <= tr_d;
            err_q      <= err_d;
            mem_q      <= mem_d;
            a_row_q    <= a_row_d;
            a_addr_q   <= a_addr_d;
            a_rvalid_q <= a_rvalid_d;
            b_row_q    <= b_row_d;
            b_addr_q   <= b_addr_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

endmodule

// File: tb/tb_mat_row_bank.sv
// Directed self-checking bench for mat_row_bank with three banks so out-of-range bank indices are reachable.
module tb_mat_row_bank;

    localparam int SIZE      = 4;
    localparam int WIDTH     = 64;
    localparam int NUM_BANKS = 3;
    localparam int AW        = 2;
    localparam int BW        = 2;
    localparam int EW        = 2 * WIDTH;
    localparam int ROW_W     = SIZE * EW;

    logic             clk;
    logic             rst_i;
    logic             a_rd_valid_i, b_rd_valid_i;
    logic [BW-1:0]    a_rd_bank_i, b_rd_bank_i;
    logic [AW-1:0]    a_rd_addr_i, b_rd_addr_i;
    logic             a_rd_col_i, b_rd_col_i;
    logic [ROW_W-1:0] a_rd_row_o, b_rd_row_o;
    logic [AW-1:0]    a_rd_addr_o, b_rd_addr_o;
    logic             a_rd_rvalid_o, b_rd_rvalid_o;
    logic             wr_valid_i, wr_ready_o;
    logic [BW-1:0]    wr_bank_i;
    logic [AW-1:0]    wr_addr_i;
    logic [ROW_W-1:0] wr_row_i;
    logic             copy_valid_i;
    logic [BW-1:0]    copy_src_i, copy_dst_i;
    logic             copy_transpose_i;
    logic             copy_done_o, copy_err_o, busy_o;

    int assert_count = 0;
    int fail_count   = 0;
    logic [ROW_W-1:0] model [NUM_BANKS][SIZE];
    logic [ROW_W-1:0] tmp_row;

    mat_row_bank #(.SIZE(SIZE), .WIDTH(WIDTH), .NUM_BANKS(NUM_BANKS)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .a_rd_valid_i(a_rd_valid_i), .a_rd_bank_i(a_rd_bank_i), .a_rd_addr_i(a_rd_addr_i),
        .a_rd_col_i(a_rd_col_i), .a_rd_row_o(a_rd_row_o), .a_rd_addr_o(a_rd_addr_o),
        .a_rd_rvalid_o(a_rd_rvalid_o),
        .b_rd_valid_i(b_rd_valid_i), .b_rd_bank_i(b_rd_bank_i), .b_rd_addr_i(b_rd_addr_i),
        .b_rd_col_i(b_rd_col_i), .b_rd_row_o(b_rd_row_o), .b_rd_addr_o(b_rd_addr_o),
        .b_rd_rvalid_o(b_rd_rvalid_o),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_bank_i(wr_bank_i),
        .wr_addr_i(wr_addr_i), .wr_row_i(wr_row_i),
        .copy_valid_i(copy_valid_i), .copy_src_i(copy_src_i), .copy_dst_i(copy_dst_i),
        .copy_transpose_i(copy_transpose_i), .copy_done_o(copy_done_o),
        .copy_err_o(copy_err_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] want);
        assert_count++;
        if (got !== want) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic a_v, input int a_b, input int a_a, input logic a_c,
                                 input logic b_v, input int b_b, input int b_a, input logic b_c);
        a_rd_valid_i = a_v;
        a_rd_bank_i  = BW'(a_b);
        a_rd_addr_i  = AW'(a_a);
        a_rd_col_i   = a_c;
        b_rd_valid_i = b_v;
        b_rd_bank_i  = BW'(b_b);
        b_rd_addr_i  = AW'(b_a);
        b_rd_col_i   = b_c;
    endtask

    task automatic writeRow(input int bank, input int addr, input logic [ROW_W-1:0] row);
        wr_valid_i = 1'b1;
        wr_bank_i  = BW'(bank);
        wr_addr_i  = AW'(addr);
        wr_row_i   = row;
        tick();
        wr_valid_i = 1'b0;
        model[bank][addr] = row;
    endtask

    function automatic logic [ROW_W-1:0] model_col(input int bank, input int c);
        logic [ROW_W-1:0] g;
        g = '0;
        for (int r = 0; r < SIZE; r++) begin
            g[r*EW +: EW] = model[bank][r][c*EW +: EW];
        end
        return g;
    endfunction

    // Bank 0 pattern: distinct integer parts per element, diagonal carries an extra high bit.
    function automatic logic [ROW_W-1:0] pattern_row(input int r);
        logic [ROW_W-1:0] g;
        logic [63:0] re, im;
        g = '0;
        for (int c = 0; c < SIZE; c++) begin
            re = 64'h1000 + 64'(r * 4 + c) + ((r == c) ? 64'h1_0000_0000 : 64'h0);
            im = 64'h2000 + 64'(r * 4 + c);
            g[c*EW +: EW] = {im, re};
        end
        return g;
    endfunction

    initial begin
        for (int b = 0; b < NUM_BANKS; b++)
            for (int r = 0; r < SIZE; r++)
                model[b][r] = '0;
        rst_i = 1'b1;
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        wr_valid_i = 1'b0; wr_bank_i = '0; wr_addr_i = '0; wr_row_i = '0;
        copy_valid_i = 1'b0; copy_src_i = '0; copy_dst_i = '0; copy_transpose_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;

        checkOutput("reset_a_row", a_rd_row_o, '0);
        checkOutput("reset_a_addr", ROW_W'(a_rd_addr_o), '0);
        checkOutput("reset_a_rvalid", ROW_W'(a_rd_rvalid_o), '0);
        checkOutput("reset_b_rvalid", ROW_W'(b_rd_rvalid_o), '0);
        checkOutput("reset_wr_ready", ROW_W'(wr_ready_o), 1);
        checkOutput("reset_busy", ROW_W'(busy_o), '0);
        checkOutput("reset_done", ROW_W'(copy_done_o), '0);
        checkOutput("reset_err", ROW_W'(copy_err_o), '0);

        // Complex doubles (j+1, -(j+1)) in bank 1 row 2.
        tmp_row = '0;
        for (int j = 0; j < SIZE; j++)
            tmp_row[j*EW +: EW] = {$realtobits(-real'(j + 1)), $realtobits(real'(j + 1))};
        writeRow(1, 2, tmp_row);
        applyStimulus(1'b1, 1, 2, 1'b0, 1'b0, 0, 0, 1'b0);
        tick();
        checkOutput("rd1_rvalid", ROW_W'(a_rd_rvalid_o), 1);
        checkOutput("rd1_data", a_rd_row_o, model[1][2]);
        checkOutput("rd1_addr", ROW_W'(a_rd_addr_o), 2);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        tick();
        checkOutput("rd1_rvalid_drop", ROW_W'(a_rd_rvalid_o), '0);

        for (int r = 0; r < SIZE; r++)
            writeRow(0, r, pattern_row(r));
        applyStimulus(1'b1, 0, 1, 1'b0, 1'b1, 0, 3, 1'b1);
        tick();
        checkOutput("col3_b_data", b_rd_row_o, model_col(0, 3));
        checkOutput("col3_b_addr", ROW_W'(b_rd_addr_o), 3);
        checkOutput("row1_a_data", a_rd_row_o, model[0][1]);
        checkOutput("row1_a_rvalid", ROW_W'(a_rd_rvalid_o), 1);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);

        // Transposed copy 0 -> 2; a junk write to bank 1 row 0 is held up the whole time.
        copy_valid_i = 1'b1; copy_src_i = 2'd0; copy_dst_i = 2'd2; copy_transpose_i = 1'b1;
        tick();
        copy_valid_i = 1'b0;
        for (int k = 1; k <= SIZE + 1; k++) begin
            checkOutput($sformatf("copy_busy_c%0d", k), ROW_W'(busy_o), 1);
            checkOutput($sformatf("copy_ready_c%0d", k), ROW_W'(wr_ready_o), '0);
            checkOutput($sformatf("copy_done_c%0d", k), ROW_W'(copy_done_o), (k == SIZE + 1) ? 1 : 0);
            wr_valid_i = 1'b1; wr_bank_i = 2'd1; wr_addr_i = 2'd0; wr_row_i = {(ROW_W/8){8'h5C}};
            tick();
        end
        wr_valid_i = 1'b0;
        checkOutput("copy_busy_after", ROW_W'(busy_o), '0);
        checkOutput("copy_done_after", ROW_W'(copy_done_o), '0);
        for (int r = 0; r < SIZE; r++)
            model[2][r] = model_col(0, r);
        for (int r = 0; r < SIZE; r++) begin
            applyStimulus(1'b1, 2, r, 1'b0, 1'b1, 1, 0, 1'b0);
            tick();
            checkOutput($sformatf("copy_dst_row%0d", r), a_rd_row_o, model[2][r]);
            checkOutput($sformatf("blocked_wr_r%0d", r), b_rd_row_o, model[1][0]);
        end
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);

        copy_valid_i = 1'b1; copy_src_i = 2'd1; copy_dst_i = 2'd1; copy_transpose_i = 1'b0;
        tick();
        copy_valid_i = 1'b0;
        checkOutput("err_same_pulse", ROW_W'(copy_err_o), 1);
        checkOutput("err_same_busy", ROW_W'(busy_o), '0);
        tick();
        checkOutput("err_same_clear", ROW_W'(copy_err_o), '0);
        copy_valid_i = 1'b1; copy_src_i = 2'd0; copy_dst_i = 2'd3;
        applyStimulus(1'b1, 3, 0, 1'b0, 1'b1, 1, 2, 1'b0);
        tick();
        copy_valid_i = 1'b0;
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        checkOutput("err_range_pulse", ROW_W'(copy_err_o), 1);
        checkOutput("err_range_busy", ROW_W'(busy_o), '0);
        checkOutput("oob_read_rvalid", ROW_W'(a_rd_rvalid_o), 1);
        checkOutput("oob_read_zero", a_rd_row_o, '0);
        checkOutput("bank1_unchanged", b_rd_row_o, model[1][2]);
        tick();
        checkOutput("err_range_clear", ROW_W'(copy_err_o), '0);

        // Same-cycle write and read of bank 0 row 0.
        wr_valid_i = 1'b1; wr_bank_i = 2'd0; wr_addr_i = 2'd0; wr_row_i = {(ROW_W/8){8'hAA}};
        applyStimulus(1'b1, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        tick();
        wr_valid_i = 1'b0;
`ifdef MAT_ROW_BANK_BYPASS_EN
        checkOutput("same_cycle_rd", a_rd_row_o, {(ROW_W/8){8'hAA}});
`else
        checkOutput("same_cycle_rd", a_rd_row_o, model[0][0]);
`endif
        model[0][0] = {(ROW_W/8){8'hAA}};
        tick();
        checkOutput("after_write_rd", a_rd_row_o, model[0][0]);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);

        // Reset during the second copy cycle.
        copy_valid_i = 1'b1; copy_src_i = 2'd0; copy_dst_i = 2'd1; copy_transpose_i = 1'b0;
        tick();
        copy_valid_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checkOutput("rst_mid_busy", ROW_W'(busy_o), '0);
        checkOutput("rst_mid_done", ROW_W'(copy_done_o), '0);
        checkOutput("rst_mid_ready", ROW_W'(wr_ready_o), 1);
        for (int k = 0; k < SIZE + 2; k++) begin
            tick();
            checkOutput($sformatf("rst_no_done_%0d", k), ROW_W'(copy_done_o), '0);
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int r = 0; r < SIZE; r++) begin
                applyStimulus(1'b1, b, r, 1'b0, 1'b1, b, r, 1'b1);
                tick();
                checkOutput($sformatf("rst_clear_row_b%0d_r%0d", b, r), a_rd_row_o, '0);
                checkOutput($sformatf("rst_clear_col_b%0d_c%0d", b, r), b_rd_row_o, '0);
            end
        end
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
